pkt_parse: RTL and testbench
============================

PKT_PARSE -- requirements
Module: pkt_parse

Interface
REQ-001 Parameter DW, default 32, data word width in bits (byte count per word = DW/8).
REQ-002 Parameter HQ_DEPTH, default 4, header queue depth in entries (power of two, >=2).
REQ-003 clk  input  1  sole clock; all logic rising-edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 i_sop  input  1  start-of-packet pulse; i_vld is 0 in that cycle.
REQ-006 i_vld  input  1  i_data valid; first valid word after i_sop is the header.
REQ-007 i_data  input  DW  header or payload word.
REQ-008 i_eop  input  1  end-of-packet pulse; i_vld is 0 in that cycle.
REQ-009 o_ready  output  1  high = a new i_sop is accepted; upstream starts no packet while low.
REQ-010 o_hdr_vld / i_hdr_rdy  output/input  1/1  header-queue handshake; pop when both high.
REQ-011 o_hdr_da / o_hdr_prior / o_hdr_len  output  4/3/10  queue-head fields.
REQ-012 o_hdr_err  output  1  queue-head packet failed protocol/length checks.
REQ-013 o_pld_vld / o_pld_data / o_pld_last  output  1/DW/1  payload stream; last marks final payload word.
REQ-014 o_err_cnt  output  16  saturating error count (CHK_EN only; else tied 0).

Function
REQ-015 Header decode: da=i_data[3:0], prior=i_data[6:4], len=i_data[16:7]; bits [DW-1:17] ignored.
REQ-016 FSM states IDLE, HDR, PLD, DROP.
REQ-017 IDLE: i_sop && o_ready -> HDR; i_vld or i_eop in IDLE -> protocol error, stay IDLE, nothing emitted.
REQ-018 HDR: i_vld -> latch fields, clear word counter -> PLD; i_eop -> error, queue entry with err=1, len=0 -> IDLE.
REQ-019 PLD: each i_vld increments 11-bit word counter and emits payload word; i_eop -> push header entry -> IDLE.
REQ-020 i_sop in HDR or PLD -> error; current packet closed with err=1 (entry pushed), FSM -> HDR for new packet.
REQ-021 Payload latency: o_pld_vld/o_pld_data exactly 1 cycle after i_vld in PLD; header word never on payload port.
REQ-022 o_pld_last: one-word skid delay; the held word is emitted with last=1 in the cycle after i_eop, or normally if another i_vld arrives.
REQ-023 Header entry pushed the cycle after i_eop (same cycle as o_pld_last), visible on o_hdr_vld one cycle later.
REQ-024 Expected payload words = max(1, ceil(len/(DW/8))); mismatch with counter at i_eop sets err (CHK_EN only).
REQ-025 Word counter saturates at 2047; no wrap.
REQ-026 o_ready = 0 when queue occupancy >= HQ_DEPTH-1 or FSM not IDLE; 1 otherwise.
REQ-027 Queue full at push (upstream violation) -> entry dropped, error counted; never overwrites.
REQ-028 Simultaneous push and pop with queue full or empty is legal; occupancy unchanged.
REQ-029 Queue head fields stable while o_hdr_vld && !i_hdr_rdy.

Reset
REQ-030 rst high: FSM IDLE, queue empty, counters 0, all outputs 0 except o_ready=1.
REQ-031 rst mid-packet discards partial packet; no entry and no o_pld_last emitted afterwards.

Configuration
REQ-032 Macro PKT_PARSE_CHK_EN defined: length check (REQ-024) and o_err_cnt saturating at 16'hFFFF active, +1 per detected error.
REQ-033 Macro undefined: no length check, o_hdr_err reflects protocol errors only, o_err_cnt constant 0, counter logic absent.

Structure
REQ-034 Shared package pkt_pkg: header field offsets/widths, header struct typedef, FSM state enum.
REQ-035 One sub-module pkt_hdr_fifo: synchronous FIFO, width 18 (da, prior, len, err), depth HQ_DEPTH.

Verification
REQ-036 len=12, DW=32: sop, hdr, 3 data, eop -> 3 o_pld_vld, last on 3rd, entry da/prior/len match, err=0.
REQ-037 len=0: sop, hdr, 1 data, eop -> 1 payload word with last=1, err=0; with 2 data words err=1, o_err_cnt=1 (CHK_EN).
REQ-038 i_hdr_rdy held 0, 3 packets with HQ_DEPTH=4 -> o_ready low after 3rd push; release rdy -> pops in order, o_ready returns.
REQ-039 i_sop during PLD after 2 words -> first entry err=1, o_pld_last on 2nd word, second packet parsed cleanly.
REQ-040 rst asserted after header + 1 data word -> all outputs 0, o_ready=1, queue empty; next packet parses correctly.

Source files
------------

// File: rtl/pkt_pkg.sv
// Shared definitions for the packet parser: header field layout, queue entry
// types, the parser FSM state encoding and small decode helpers.
package pkt_pkg;

    localparam int DA_LSB    = 0;
    localparam int DA_W      = 4;
    localparam int PRIOR_LSB = 4;
    localparam int PRIOR_W   = 3;
    localparam int LEN_LSB   = 7;
    localparam int LEN_W     = 10;
    localparam int HDR_BITS  = LEN_LSB + LEN_W;

    localparam int               WCNT_W    = 11;
    localparam logic [WCNT_W-1:0] WCNT_MAX = '1;
    localparam int               ERR_CNT_W = 16;

    typedef struct packed {
        logic [DA_W-1:0]    da;
        logic [PRIOR_W-1:0] prior;
        logic [LEN_W-1:0]   len;
    } hdr_fields_t;

    typedef struct packed {
        hdr_fields_t f;
        logic        err;
    } hdr_entry_t;

    localparam hdr_fields_t NO_FIELDS = '0;
    localparam hdr_entry_t  NO_ENTRY  = '0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_PLD,
        ST_DROP
    } state_t;

    function automatic hdr_fields_t decode_hdr(input logic [HDR_BITS-1:0] w);
        hdr_fields_t h;
        h.da    = w[DA_LSB +: DA_W];
        h.prior = w[PRIOR_LSB +: PRIOR_W];
        h.len   = w[LEN_LSB +: LEN_W];
        return h;
    endfunction

    // A zero-length packet still carries one payload word.
    function automatic logic [WCNT_W-1:0] exp_words(input logic [LEN_W-1:0] len,
                                                    input int bytes_per_word);
        int w;
        w = (int'(len) + bytes_per_word - 1) / bytes_per_word;
        if (w < 1) w = 1;
        return WCNT_W'(w);
    endfunction

endpackage

// File: rtl/pkt_hdr_fifo.sv
// Header queue: synchronous FIFO of parsed header entries. A push into a full
// queue is accepted only when a pop frees a slot in the same cycle.
module pkt_hdr_fifo
    import pkt_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  hdr_entry_t               push_data,
    input  logic                     pop,
    output hdr_entry_t               head,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int             AW        = $clog2(DEPTH);
    localparam logic [AW:0]    DEPTH_CNT = (AW+1)'(DEPTH);

    hdr_entry_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_CNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? NO_ENTRY : mem[rd_ptr];

    // NOTE: storage has no reset; the head is masked while empty, so stale contents never reach an output.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pkt_parse.sv
// Packet parser: splits header/payload, queues decoded headers and streams
// payload with a one-word skid for the last flag. Define PKT_PARSE_CHK_EN for length checking and error counting.
module pkt_parse
    import pkt_pkg::*;
#(
    parameter int DW       = 32,
    parameter int HQ_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_sop,
    input  logic                 i_vld,
    input  logic [DW-1:0]        i_data,
    input  logic                 i_eop,
    output logic                 o_ready,
    output logic                 o_hdr_vld,
    input  logic                 i_hdr_rdy,
    output logic [DA_W-1:0]      o_hdr_da,
    output logic [PRIOR_W-1:0]   o_hdr_prior,
    output logic [LEN_W-1:0]     o_hdr_len,
    output logic                 o_hdr_err,
    output logic                 o_pld_vld,
    output logic [DW-1:0]        o_pld_data,
    output logic                 o_pld_last,
    output logic [ERR_CNT_W-1:0] o_err_cnt
);

    localparam int             QCW         = $clog2(HQ_DEPTH) + 1;
    localparam logic [QCW-1:0] READY_LIMIT = QCW'(HQ_DEPTH - 1);

    state_t      state_q, state_d;
    logic        latch_hdr, take_word, close_pkt, close_proto, hdr_only, proto_err;
    logic        len_err;
    hdr_fields_t hdr_q;
    logic        held_vld;
    logic [DW-1:0] held_data;
    logic        push_q;
    hdr_entry_t  push_entry_q;
    hdr_entry_t  hq_head;
    logic        hq_empty;
    logic        hq_pop;
    logic [QCW-1:0] hq_count;

    assign o_ready = (state_q == ST_IDLE) && (hq_count < READY_LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every output gets a default before the case, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        latch_hdr   = 1'b0;
        take_word   = 1'b0;
        close_pkt   = 1'b0;
        close_proto = 1'b0;
        hdr_only    = 1'b0;
        proto_err   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_sop && o_ready)            state_d = ST_HDR;
                else if (i_sop || i_vld || i_eop) proto_err = 1'b1;
            end
            ST_HDR: begin
                if (i_sop || i_eop) begin
                    close_pkt   = 1'b1;
                    close_proto = 1'b1;
                    hdr_only    = 1'b1;
                    proto_err   = 1'b1;
                    state_d     = i_sop ? ST_HDR : ST_IDLE;
                end else if (i_vld) begin
                    latch_hdr = 1'b1;
                    state_d   = ST_PLD;
                end
            end
            ST_PLD: begin
                if (i_sop) begin
                    close_pkt   = 1'b1;
                    close_proto = 1'b1;
                    proto_err   = 1'b1;
                    state_d     = ST_HDR;
                end else if (i_eop) begin
                    close_pkt = 1'b1;
                    state_d   = ST_IDLE;
                end else if (i_vld) begin
                    take_word = 1'b1;
                end
            end
            // Recovery state: swallow words until the next packet boundary.
            ST_DROP: begin
                if (i_sop)      state_d = ST_HDR;
                else if (i_eop) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hdr_q        <= NO_FIELDS;
            held_vld     <= 1'b0;
            held_data    <= '0;
            o_pld_vld    <= 1'b0;
            o_pld_data   <= '0;
            o_pld_last   <= 1'b0;
            push_q       <= 1'b0;
            push_entry_q <= NO_ENTRY;
        end else begin
            o_pld_vld  <= 1'b0;
            o_pld_last <= 1'b0;
            push_q     <= close_pkt;
            if (close_pkt) begin
                push_entry_q.f   <= hdr_only ? NO_FIELDS : hdr_q;
                push_entry_q.err <= close_proto | len_err;
            end
            if (latch_hdr) hdr_q <= decode_hdr(i_data[HDR_BITS-1:0]);
            if (take_word) begin
                if (held_vld) begin
                    o_pld_vld  <= 1'b1;
                    o_pld_data <= held_data;
                end
                held_vld  <= 1'b1;
                held_data <= i_data;
            end else if (close_pkt) begin
                if (held_vld) begin
                    o_pld_vld  <= 1'b1;
                    o_pld_last <= 1'b1;
                    o_pld_data <= held_data;
                end
                held_vld <= 1'b0;
            end
        end
    end

    pkt_hdr_fifo #(
        .DEPTH (HQ_DEPTH)
    ) u_hdr_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_q),
        .push_data (push_entry_q),
        .pop       (hq_pop),
        .head      (hq_head),
        .empty     (hq_empty),
        .count     (hq_count)
    );

    assign o_hdr_vld   = !hq_empty;
    assign hq_pop      = o_hdr_vld && i_hdr_rdy;
    assign o_hdr_da    = hq_head.f.da;
    assign o_hdr_prior = hq_head.f.prior;
    assign o_hdr_len   = hq_head.f.len;
    assign o_hdr_err   = hq_head.err;

`ifdef PKT_PARSE_CHK_EN
    localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

    logic [WCNT_W-1:0]    wcnt_q;
    logic                 drop_err;
    logic [1:0]           err_inc;
    logic [ERR_CNT_W-1:0] err_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                    wcnt_q <= '0;
        else if (latch_hdr)                         wcnt_q <= '0;
        else if (take_word && wcnt_q != WCNT_MAX)   wcnt_q <= wcnt_q + WCNT_W'(1);
    end

    assign len_err  = close_pkt && !hdr_only && (wcnt_q != exp_words(hdr_q.len, DW/8));
    // A push into a full queue with no simultaneous pop is lost.
    assign drop_err = push_q && (hq_count == QCW'(HQ_DEPTH)) && !hq_pop;
    assign err_inc  = {1'b0, proto_err | len_err} + {1'b0, drop_err};

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_cnt_q <= '0;
        else if (err_cnt_q > ERR_MAX - ERR_CNT_W'(err_inc))
            err_cnt_q <= ERR_MAX;
        else
            err_cnt_q <= err_cnt_q + ERR_CNT_W'(err_inc);
    end

    assign o_err_cnt = err_cnt_q;
`else
    assign len_err   = 1'b0;
    assign o_err_cnt = '0;
`endif

endmodule

// File: tb/tb_pkt_parse.sv
// Directed self-checking bench for pkt_parse (DW=32, HQ_DEPTH=4); expected
// error-related values follow PKT_PARSE_CHK_EN.
module tb_pkt_parse;

    localparam int DW       = 32;
    localparam int HQ_DEPTH = 4;
`ifdef PKT_PARSE_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          i_sop, i_vld, i_eop, i_hdr_rdy;
    logic [DW-1:0] i_data;
    logic          o_ready, o_hdr_vld, o_hdr_err;
    logic [3:0]    o_hdr_da;
    logic [2:0]    o_hdr_prior;
    logic [9:0]    o_hdr_len;
    logic          o_pld_vld, o_pld_last;
    logic [DW-1:0] o_pld_data;
    logic [15:0]   o_err_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pkt_parse #(
        .DW       (DW),
        .HQ_DEPTH (HQ_DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_sop       (i_sop),
        .i_vld       (i_vld),
        .i_data      (i_data),
        .i_eop       (i_eop),
        .o_ready     (o_ready),
        .o_hdr_vld   (o_hdr_vld),
        .i_hdr_rdy   (i_hdr_rdy),
        .o_hdr_da    (o_hdr_da),
        .o_hdr_prior (o_hdr_prior),
        .o_hdr_len   (o_hdr_len),
        .o_hdr_err   (o_hdr_err),
        .o_pld_vld   (o_pld_vld),
        .o_pld_data  (o_pld_data),
        .o_pld_last  (o_pld_last),
        .o_err_cnt   (o_err_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one input cycle, let it be sampled, then return inputs to idle.
    task automatic drive(input logic sop, input logic vld, input logic [31:0] data, input logic eop);
        i_sop  = sop;
        i_vld  = vld;
        i_data = data;
        i_eop  = eop;
        step();
        i_sop  = 1'b0;
        i_vld  = 1'b0;
        i_data = '0;
        i_eop  = 1'b0;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic pop();
        i_hdr_rdy = 1'b1;
        step();
        i_hdr_rdy = 1'b0;
    endtask

    task automatic check_head(input string tag, input logic [3:0] da, input logic [2:0] pr,
                              input logic [9:0] len, input logic err);
        check({tag, " hdr_vld"}, 32'(o_hdr_vld), 32'd1);
        check({tag, " da"},      32'(o_hdr_da),  32'(da));
        check({tag, " prior"},   32'(o_hdr_prior), 32'(pr));
        check({tag, " len"},     32'(o_hdr_len), 32'(len));
        check({tag, " err"},     32'(o_hdr_err), 32'(err));
    endtask

    task automatic check_pld(input string tag, input logic vld, input logic [31:0] data, input logic last);
        check({tag, " pld_vld"}, 32'(o_pld_vld), 32'(vld));
        if (vld) check({tag, " pld_data"}, o_pld_data, data);
        check({tag, " pld_last"}, 32'(o_pld_last), 32'(last));
    endtask

    // Header word with junk in the ignored upper bits.
    function automatic logic [31:0] hw(input logic [3:0] da, input logic [2:0] pr, input logic [9:0] len);
        return {15'h5A3C, len, pr, da};
    endfunction

    initial begin
        rst = 1'b1;
        i_sop = 1'b0; i_vld = 1'b0; i_eop = 1'b0; i_data = '0; i_hdr_rdy = 1'b0;
        repeat (3) step();
        check("rst o_ready",   32'(o_ready),   32'd1);
        check("rst hdr_vld",   32'(o_hdr_vld), 32'd0);
        check("rst hdr_da",    32'(o_hdr_da),  32'd0);
        check("rst hdr_len",   32'(o_hdr_len), 32'd0);
        check("rst hdr_err",   32'(o_hdr_err), 32'd0);
        check("rst pld_vld",   32'(o_pld_vld), 32'd0);
        check("rst pld_data",  o_pld_data,     32'd0);
        check("rst pld_last",  32'(o_pld_last), 32'd0);
        check("rst err_cnt",   32'(o_err_cnt), 32'd0);
        rst = 1'b0;
        step();

        // len=12, three payload words
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        check("A ready busy", 32'(o_ready), 32'd0);
        drive(1'b0, 1'b1, hw(4'd5, 3'd3, 10'd12), 1'b0);
        check_pld("A hdr", 1'b0, 32'h0, 1'b0);
        drive(1'b0, 1'b1, 32'h1111_0001, 1'b0);
        check_pld("A w0 held", 1'b0, 32'h0, 1'b0);
        drive(1'b0, 1'b1, 32'h1111_0002, 1'b0);
        check_pld("A w0", 1'b1, 32'h1111_0001, 1'b0);
        drive(1'b0, 1'b1, 32'h1111_0003, 1'b0);
        check_pld("A w1", 1'b1, 32'h1111_0002, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        check_pld("A w2", 1'b1, 32'h1111_0003, 1'b1);
        check("A hdr not yet", 32'(o_hdr_vld), 32'd0);
        check("A ready idle",  32'(o_ready),   32'd1);
        idle();
        check_head("A", 4'd5, 3'd3, 10'd12, 1'b0);
        check_pld("A after", 1'b0, 32'h0, 1'b0);
        idle();
        check("A head stable", 32'(o_hdr_da), 32'd5);
        pop();
        check("A popped", 32'(o_hdr_vld), 32'd0);

        // len=0, one word
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        drive(1'b0, 1'b1, hw(4'd1, 3'd0, 10'd0), 1'b0);
        drive(1'b0, 1'b1, 32'h2222_0001, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        check_pld("B w0", 1'b1, 32'h2222_0001, 1'b1);
        idle();
        check_head("B", 4'd1, 3'd0, 10'd0, 1'b0);
        pop();

        // len=0, two words: length error when checking is enabled
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        drive(1'b0, 1'b1, hw(4'd2, 3'd7, 10'd0), 1'b0);
        drive(1'b0, 1'b1, 32'h3333_0001, 1'b0);
        drive(1'b0, 1'b1, 32'h3333_0002, 1'b0);
        check_pld("C w0", 1'b1, 32'h3333_0001, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        check_pld("C w1", 1'b1, 32'h3333_0002, 1'b1);
        idle();
        check_head("C", 4'd2, 3'd7, 10'd0, CHK);
        check("C err_cnt", 32'(o_err_cnt), CHK ? 32'd1 : 32'd0);
        pop();

        // sop during payload after two words, then a clean packet
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        drive(1'b0, 1'b1, hw(4'd3, 3'd2, 10'd8), 1'b0);
        drive(1'b0, 1'b1, 32'h4444_0001, 1'b0);
        drive(1'b0, 1'b1, 32'h4444_0002, 1'b0);
        check_pld("D w0", 1'b1, 32'h4444_0001, 1'b0);
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        check_pld("D w1 closed", 1'b1, 32'h4444_0002, 1'b1);
        check("D ready in hdr", 32'(o_ready), 32'd0);
        drive(1'b0, 1'b1, hw(4'd4, 3'd1, 10'd4), 1'b0);
        check_head("D first", 4'd3, 3'd2, 10'd8, 1'b1);
        check_pld("D hdr2", 1'b0, 32'h0, 1'b0);
        drive(1'b0, 1'b1, 32'h4444_0003, 1'b0);
        check_pld("D w2 held", 1'b0, 32'h0, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        check_pld("D w2", 1'b1, 32'h4444_0003, 1'b1);
        idle();
        pop();
        check_head("D second", 4'd4, 3'd1, 10'd4, 1'b0);
        check("D err_cnt", 32'(o_err_cnt), CHK ? 32'd2 : 32'd0);
        pop();
        check("D drained", 32'(o_hdr_vld), 32'd0);

        // stray valid in IDLE: nothing emitted, error counted
        drive(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
        check_pld("S stray", 1'b0, 32'h0, 1'b0);
        idle();
        check("S no entry", 32'(o_hdr_vld), 32'd0);
        check("S err_cnt",  32'(o_err_cnt), CHK ? 32'd3 : 32'd0);

        // queue back-pressure: three packets with i_hdr_rdy held low
        for (int k = 1; k <= 3; k++) begin
            drive(1'b1, 1'b0, 32'h0, 1'b0);
            drive(1'b0, 1'b1, hw(4'(k), 3'(k), 10'd4), 1'b0);
            drive(1'b0, 1'b1, 32'h5555_0000 + 32'(k), 1'b0);
            drive(1'b0, 1'b0, 32'h0, 1'b1);
            idle();
            check($sformatf("E ready after pkt%0d", k), 32'(o_ready), (k < 3) ? 32'd1 : 32'd0);
        end
        check_head("E head1", 4'd1, 3'd1, 10'd4, 1'b0);
        idle();
        check("E head1 stable", 32'(o_hdr_da), 32'd1);
        check("E still not ready", 32'(o_ready), 32'd0);
        i_hdr_rdy = 1'b1;
        step();
        check_head("E head2", 4'd2, 3'd2, 10'd4, 1'b0);
        check("E ready back", 32'(o_ready), 32'd1);
        step();
        check_head("E head3", 4'd3, 3'd3, 10'd4, 1'b0);
        step();
        check("E drained", 32'(o_hdr_vld), 32'd0);
        i_hdr_rdy = 1'b0;

        // reset after header + one word, then a clean packet
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        drive(1'b0, 1'b1, hw(4'd6, 3'd5, 10'd8), 1'b0);
        drive(1'b0, 1'b1, 32'h6666_0001, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("F rst o_ready",  32'(o_ready),    32'd1);
        check("F rst hdr_vld",  32'(o_hdr_vld),  32'd0);
        check_pld("F rst", 1'b0, 32'h0, 1'b0);
        check("F rst err_cnt",  32'(o_err_cnt),  32'd0);
        step();
        step();
        rst = 1'b0;
        idle();
        check_pld("F post1", 1'b0, 32'h0, 1'b0);
        idle();
        check_pld("F post2", 1'b0, 32'h0, 1'b0);
        check("F no entry", 32'(o_hdr_vld), 32'd0);
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        drive(1'b0, 1'b1, hw(4'd9, 3'd4, 10'd5), 1'b0);
        drive(1'b0, 1'b1, 32'h7777_0001, 1'b0);
        drive(1'b0, 1'b1, 32'h7777_0002, 1'b0);
        check_pld("F w0", 1'b1, 32'h7777_0001, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        check_pld("F w1", 1'b1, 32'h7777_0002, 1'b1);
        idle();
        check_head("F", 4'd9, 3'd4, 10'd5, 1'b0);
        check("F err_cnt", 32'(o_err_cnt), 32'd0);
        pop();
        check("F drained", 32'(o_hdr_vld), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
